// File: rtl/channel_strip.sv
// Keypad-driven channel strip UI: scans and debounces a 4x4 keypad, edits four
// two-digit BCD parameters with mute flags, and drives a multiplexed 4-digit display.
module channel_strip #(
    parameter int SCAN_DIV    = 256,
    parameter int DEBOUNCE    = 4096,
    parameter int REFRESH_DIV = 1024
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    output logic [3:0] kpc,
    input  logic [3:0] kpr,
    output logic [7:0] leds,
    output logic [3:0] ct
);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);

    // Key values: 0-9 digits, 10-13 = A-D, 14 = '*', 15 = '#'.
    localparam logic [3:0] K_STAR = 4'd14;
    localparam logic [3:0] K_HASH = 4'd15;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t          state_q, state_d;
    logic [3:0]      kpr_s1_q, kpr_s2_q;
    logic [1:0]      col_q, col_d;
    logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [3:0]      code_q, code_d;
    logic            ev_q, ev_d;
    logic [3:0]      ev_key_q, ev_key_d;
    logic            any_low;
    logic [1:0]      row_idx;
    logic [3:0]      cur_code;

    logic [3:0][3:0] tens_q, ones_q;
    logic [3:0]      mute_q;
    logic [1:0]      sel_q;

    logic [RW-1:0]   ref_cnt_q;
    logic [1:0]      dig_q, dig_nxt;
    logic [7:0]      leds_q, leds_nxt;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // Index is {3-row, 3-col}: top row / leftmost column first.
    function automatic logic [3:0] key_value(input logic [3:0] code);
        case ({~code[1:0], ~code[3:2]})
            4'd0:  key_value = 4'd1;
            4'd1:  key_value = 4'd2;
            4'd2:  key_value = 4'd3;
            4'd3:  key_value = 4'd10;
            4'd4:  key_value = 4'd4;
            4'd5:  key_value = 4'd5;
            4'd6:  key_value = 4'd6;
            4'd7:  key_value = 4'd11;
            4'd8:  key_value = 4'd7;
            4'd9:  key_value = 4'd8;
            4'd10: key_value = 4'd9;
            4'd11: key_value = 4'd12;
            4'd12: key_value = K_STAR;
            4'd13: key_value = 4'd0;
            4'd14: key_value = K_HASH;
            default: key_value = 4'd13;
        endcase
    endfunction

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            kpr_s1_q <= 4'hF;
            kpr_s2_q <= 4'hF;
        end else begin
            kpr_s1_q <= kpr;
            kpr_s2_q <= kpr_s1_q;
        end
    end

    always_comb begin
        any_low = ~&kpr_s2_q;
        if (!kpr_s2_q[3])      row_idx = 2'd3;
        else if (!kpr_s2_q[2]) row_idx = 2'd2;
        else if (!kpr_s2_q[1]) row_idx = 2'd1;
        else                   row_idx = 2'd0;
        cur_code = {col_q, row_idx};
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            col_q      <= 2'd3;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            code_q     <= '0;
            ev_q       <= 1'b0;
            ev_key_q   <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            code_q     <= code_d;
            ev_q       <= ev_d;
            ev_key_q   <= ev_key_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        code_d     = code_q;
        ev_d       = 1'b0;
        ev_key_d   = ev_key_q;
        case (state_q)
            IDLE: begin
                if (any_low) begin
                    state_d    = PRESS_WAIT;
                    deb_cnt_d  = '0;
                    code_d     = cur_code;
                    scan_cnt_d = '0;
                end else if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    col_d      = col_q - 2'd1;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            PRESS_WAIT: begin
                if (!any_low) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (cur_code != code_q) begin
                    code_d    = cur_code;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = HELD;
                    deb_cnt_d = '0;
                    ev_d      = 1'b1;
                    ev_key_d  = key_value(code_q);
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!any_low) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end
            end
            default: begin
                if (any_low) begin
                    state_d   = HELD;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // A-D map to sel 0-3: low two bits of 10..13 minus two.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            tens_q <= '0;
            ones_q <= '0;
            mute_q <= '0;
            sel_q  <= 2'd0;
        end else if (ev_q) begin
            if (ev_key_q < 4'd10) begin
                tens_q[sel_q] <= ones_q[sel_q];
                ones_q[sel_q] <= ev_key_q;
            end else if (ev_key_q == K_STAR) begin
                tens_q[sel_q] <= 4'd0;
                ones_q[sel_q] <= 4'd0;
            end else if (ev_key_q == K_HASH) begin
                mute_q[sel_q] <= ~mute_q[sel_q];
            end else begin
                sel_q <= ev_key_q[1:0] - 2'd2;
            end
        end
    end

    always_comb begin
        dig_nxt = dig_q + 2'd1;
        case (dig_nxt)
            2'd0: leds_nxt = seg7(ones_q[sel_q]) & {~mute_q[sel_q], 7'h7F};
            2'd1: leds_nxt = seg7(tens_q[sel_q]);
            2'd2: leds_nxt = 8'hFF;
            default: begin
                case (sel_q)
                    2'd0:    leds_nxt = 8'h88;
                    2'd1:    leds_nxt = 8'h83;
                    2'd2:    leds_nxt = 8'hC6;
                    default: leds_nxt = 8'hA1;
                endcase
            end
        endcase
    end

    // Pattern is loaded on the same edge the digit enable moves.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt_q <= '0;
            dig_q     <= 2'd0;
            leds_q    <= 8'hC0;
        end else if (ref_cnt_q == REF_LAST) begin
            ref_cnt_q <= '0;
            dig_q     <= dig_nxt;
            leds_q    <= leds_nxt;
        end else begin
            ref_cnt_q <= ref_cnt_q + 1'b1;
        end
    end

    assign kpc  = ~(4'b0001 << col_q);
    assign ct   = 4'b0001 << dig_q;
    assign leds = leds_q;
endmodule

// File: tb/tb_channel_strip.sv
// Scoreboarded bench for channel_strip: keypad model driven by kpc, reference
// model of parameter state, display read back digit by digit.
module tb_channel_strip;
    localparam int SCAN = 16;
    localparam int DEB  = 128;
    localparam int REF  = 8;
    localparam int PRESS_CYC   = 2 + 4 * SCAN + DEB + 60;
    localparam int RELEASE_CYC = DEB + 50;

    localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    localparam logic [7:0] LETTER [4] = '{8'h88, 8'h83, 8'hC6, 8'hA1};
    // Keypad layout, top row first, leftmost column first. A-D=10-13, *=14, #=15.
    localparam logic [3:0] LAYOUT [16] = '{4'd1, 4'd2, 4'd3, 4'd10,
                                           4'd4, 4'd5, 4'd6, 4'd11,
                                           4'd7, 4'd8, 4'd9, 4'd12,
                                           4'd14, 4'd0, 4'd15, 4'd13};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] kpc, kpr, ct;
    logic [7:0] leds;

    logic       held = 1'b0;
    logic [1:0] held_r = 2'd0;
    logic [1:0] held_c = 2'd0;

    int n_vec  = 0;
    int n_miss = 0;

    int m_tens [4];
    int m_ones [4];
    bit m_mute [4];
    int m_sel;

    logic [7:0] exp_q [$];

    channel_strip #(.SCAN_DIV(SCAN), .DEBOUNCE(DEB), .REFRESH_DIV(REF)) dut (
        .CLOCK_50(clk),
        .reset_n (reset_n),
        .kpc     (kpc),
        .kpr     (kpr),
        .leds    (leds),
        .ct      (ct)
    );

    // Clock / keypad wiring.
    always #5 clk = ~clk;

    always @* begin
        kpr = 4'hF;
        if (held && kpc[held_c] == 1'b0) kpr = ~(4'b0001 << held_r);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_tens[i] = 0;
            m_ones[i] = 0;
            m_mute[i] = 1'b0;
        end
        m_sel = 0;
    endtask

    task automatic model_key(input logic [3:0] k);
        if (k < 4'd10) begin
            m_tens[m_sel] = m_ones[m_sel];
            m_ones[m_sel] = int'(k);
        end else if (k <= 4'd13) begin
            m_sel = int'(k) - 10;
        end else if (k == 4'd14) begin
            m_tens[m_sel] = 0;
            m_ones[m_sel] = 0;
        end else begin
            m_mute[m_sel] = ~m_mute[m_sel];
        end
    endtask

    task automatic push_expected();
        exp_q.push_back(SEG[m_ones[m_sel]] & (m_mute[m_sel] ? 8'h7F : 8'hFF));
        exp_q.push_back(SEG[m_tens[m_sel]]);
        exp_q.push_back(8'hFF);
        exp_q.push_back(LETTER[m_sel]);
    endtask

    task automatic hold_key(input logic [3:0] k);
        for (int i = 0; i < 16; i++) begin
            if (LAYOUT[i] == k) begin
                held_r = 2'(3 - i / 4);
                held_c = 2'(3 - i % 4);
            end
        end
        held = 1'b1;
    endtask

    task automatic press_key(input logic [3:0] k);
        hold_key(k);
        model_key(k);
        push_expected();
        repeat (PRESS_CYC) @(negedge clk);
        held = 1'b0;
        repeat (RELEASE_CYC) @(negedge clk);
    endtask

    task automatic wait_ct(input logic [3:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * REF + 8; i++) begin
            @(negedge clk);
            if (ct == want) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ct_timeout", ct, want);
    endtask

    task automatic check_display(input string tag);
        bit ok;
        logic [7:0] e;
        wait_ct(4'b1000, ok);
        for (int d = 0; d < 4; d++) begin
            wait_ct(4'b0001 << d, ok);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL %s: scoreboard empty at digit %0d", tag, d);
            end else begin
                e = exp_q.pop_front();
                if (ok) chk($sformatf("%s_d%0d", tag, d), leds, e);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_kpc"}, kpc, 4'b0111);
        chk({tag, "_ct"}, ct, 4'b0001);
        chk({tag, "_leds"}, leds, 8'hC0);
    endtask

    initial begin
        model_reset();

        // Reset held with keypad idle.
        for (int i = 0; i < 4; i++) begin
            repeat (50) @(negedge clk);
            check_reset_outputs("rst_hold");
        end
        reset_n = 1'b1;
        push_expected();
        check_display("post_rst");
        repeat (100) @(negedge clk);

        // Single long hold of '1': scan freezes, exactly one event.
        hold_key(4'd1);
        model_key(4'd1);
        repeat (PRESS_CYC) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("freeze_kpc", kpc, 4'b0111);
            push_expected();
            check_display("held1");
            repeat (400) @(negedge clk);
        end
        held = 1'b0;
        repeat (RELEASE_CYC) @(negedge clk);

        // Digit entry.
        press_key(4'd2);  check_display("key2");
        press_key(4'd3);  check_display("key3");

        // Select and mute.
        press_key(4'd11); check_display("selB");
        press_key(4'd15); check_display("muteB");
        press_key(4'd10); check_display("selA");

        // Bounce shorter than the debounce window.
        hold_key(4'd9);
        held = 1'b0;
        for (int i = 0; i < 8; i++) begin
            held = 1'b1;
            repeat ($urandom_range(10, DEB / 2)) @(negedge clk);
            held = 1'b0;
            repeat ($urandom_range(10, DEB / 2)) @(negedge clk);
        end
        repeat (RELEASE_CYC) @(negedge clk);
        push_expected();
        check_display("bounce");

        // Clear.
        press_key(4'd14); check_display("clear");

        // Remaining letters and digit codes.
        press_key(4'd12); check_display("selC");
        press_key(4'd4);  check_display("key4");
        press_key(4'd5);  check_display("key5");
        press_key(4'd13); check_display("selD");
        press_key(4'd6);  check_display("key6");
        press_key(4'd7);  check_display("key7");
        press_key(4'd8);  check_display("key8");
        press_key(4'd9);  check_display("key9");
        press_key(4'd0);  check_display("key0");
        press_key(4'd15); check_display("muteD");

        // Async reset while a press is still debouncing.
        hold_key(4'd5);
        repeat (80) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        held = 1'b0;
        repeat (20) @(negedge clk);
        check_reset_outputs("async_rst_hold");
        reset_n = 1'b1;
        model_reset();
        push_expected();
        check_display("after_rst");
        press_key(4'd13); check_display("selD_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
